line_buffer_feeder: RTL and testbench

//  Pixel source for line_buffer_logic: streams a raster image from an upstream valid/ready byte source into
//  the line buffer's i_pixel_data/i_pixel_data_valid. Preloads PRELOAD_LINES lines, then releases one further

---
 rtl/line_buffer_feeder.sv | 159 +++++++++++++++
 tb/tb_line_buffer_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_feeder.sv
// ----------------------------------------------------------------------------
// line_buffer_feeder
//   Streams a raster image from an upstream valid/ready byte source into a
//   line buffer. The first PRELOAD_LINES lines are sent on initial credit.
//   After that, each i_intr pulse from the line buffer releases one more line.
//   Once the image is sent, PAD_LINES lines of zeros follow so the bottom image
//   rows still reach the kernel. o_done then pulses for one cycle.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             1-cycle pulse, begins a frame (ignored while busy)
//   i_s_data/i_s_valid  upstream pixel stream
//   o_s_ready           upstream ready (combinational)
//   o_pixel_data        pixel to line buffer (registered, holds when idle)
//   o_pixel_data_valid  pixel strobe to line buffer (registered)
//   i_intr              line-consumed pulse from line buffer (+1 credit)
//   o_busy              frame in progress
//   o_done              1-cycle pulse, one cycle after the final pixel strobe
//   o_line_cnt          lines fully emitted this frame (image + pad)
// ----------------------------------------------------------------------------
module line_buffer_feeder #(
    parameter int IMG_WIDTH     = 512,
    parameter int IMG_HEIGHT    = 512,
    parameter int PRELOAD_LINES = 4,
    parameter int PAD_LINES     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_s_data,
    input  logic       i_s_valid,
    output logic       o_s_ready,
    output logic [7:0] o_pixel_data,
    output logic       o_pixel_data_valid,
    input  logic       i_intr,
    output logic       o_busy,
    output logic       o_done,
    output logic [9:0] o_line_cnt
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [9:0]       IMG_LINES = 10'(IMG_HEIGHT);
    localparam logic [9:0]       LAST_LINE = 10'(IMG_HEIGHT + PAD_LINES - 1);
    localparam logic [3:0]       PRELOAD   = 4'(PRELOAD_LINES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_credit;
    logic [COL_W-1:0] r_col;
    logic [9:0]       r_line_cnt;
    logic [7:0]       r_pixel_data;
    logic             r_pixel_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_image;
    logic             w_send;
    logic             w_has_credit;
    logic             w_ready;
    logic             w_fire;
    logic             w_line_done;
    logic             w_last_line;
    logic             w_intr;
    logic [4:0]       w_credit_sum;
    logic [3:0]       w_credit_next;

    // Lines below IMG_HEIGHT come from upstream; the rest are zero padding.
    assign w_image      = (r_line_cnt < IMG_LINES);
    assign w_send       = (r_state == SEND);
    assign w_has_credit = (r_credit != 4'd0);
    assign w_ready      = w_send & w_image & w_has_credit;

    // Pad pixels need no upstream handshake and go out every credited cycle.
    assign w_fire       = w_image ? (i_s_valid & w_ready) : (w_send & w_has_credit);
    assign w_line_done  = w_fire & (r_col == LAST_COL);
    assign w_last_line  = w_line_done & (r_line_cnt == LAST_LINE);

    // Credits are only meaningful while a frame is streaming.
    assign w_intr       = i_intr & ((r_state == SEND) | (r_state == WAIT));

    // A line completion always has credit >= 1, so the sum cannot underflow.
    // An i_intr arriving together with a line completion cancels it, so the
    // credit never passes through zero.
    assign w_credit_sum  = {1'b0, r_credit} + {4'd0, w_intr} - {4'd0, w_line_done};
    assign w_credit_next = w_credit_sum[4] ? 4'hF : w_credit_sum[3:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_state_next = SEND;
            SEND: begin
                if (w_last_line)
                    w_state_next = DONE;
                else if (w_line_done && (w_credit_next == 4'd0))
                    w_state_next = WAIT;
            end
            WAIT: if (w_has_credit) w_state_next = SEND;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_credit      <= 4'd0;
            r_col         <= '0;
            r_line_cnt    <= 10'd0;
            r_pixel_data  <= 8'd0;
            r_pixel_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Registering the DONE state places the pulse one cycle after the
            // final pixel strobe.
            r_done  <= (r_state == DONE);

            if ((r_state == IDLE) && i_start) begin
                r_credit   <= PRELOAD;
                r_col      <= '0;
                r_line_cnt <= 10'd0;
                r_busy     <= 1'b1;
            end else begin
                r_credit <= w_credit_next;
                if (r_state == DONE)
                    r_busy <= 1'b0;
                if (w_fire) begin
                    if (w_line_done) begin
                        r_col      <= '0;
                        r_line_cnt <= r_line_cnt + 10'd1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end

            r_pixel_valid <= w_fire;
            if (w_fire)
                r_pixel_data <= w_image ? i_s_data : 8'h00;
        end
    end

    assign o_s_ready          = w_ready;
    assign o_pixel_data       = r_pixel_data;
    assign o_pixel_data_valid = r_pixel_valid;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_line_cnt         = r_line_cnt;

endmodule

// File: tb/tb_line_buffer_feeder.sv
// ----------------------------------------------------------------------------
// tb_line_buffer_feeder
//   Directed bench for line_buffer_feeder on a reduced frame: 16x8 image,
//   4 preload lines and 2 pad lines. A full frame needs 10 lines in total,
//   which is 6 i_intr pulses after the preload. Inputs are driven 1 ns after
//   each rising edge, and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_line_buffer_feeder;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int PRE = 4;
    localparam int PAD = 2;

    logic       clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_s_data;
    logic       i_s_valid;
    logic       o_s_ready;
    logic [7:0] o_pixel_data;
    logic       o_pixel_data_valid;
    logic       i_intr;
    logic       o_busy;
    logic       o_done;
    logic [9:0] o_line_cnt;

    line_buffer_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(PRE), .PAD_LINES(PAD)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
        .i_intr(i_intr), .o_busy(o_busy), .o_done(o_done), .o_line_cnt(o_line_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] inq[$];
    logic [7:0] outq[$];
    int cyc = 0;
    int nxt = 0;
    int rdy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_vld_cyc = -1;

    function automatic logic [7:0] pix(input int n);
        return 8'(n * 37 + 11);
    endfunction

    // Advances one clock. Records accepted upstream bytes and emitted pixels.
    task automatic step();
        logic       x;
        logic [7:0] d;
        x = i_s_valid & o_s_ready;
        d = i_s_data;
        if (o_s_ready) rdy_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (x) begin
            inq.push_back(d);
            nxt++;
            i_s_data = pix(nxt);
        end
        if (o_pixel_data_valid) begin
            outq.push_back(o_pixel_data);
            last_vld_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1;
        step();
        i_intr = 1'b0;
    endtask

    task automatic clear_frame();
        inq.delete();
        outq.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_vld_cyc = -1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        checks++;
        if ({o_s_ready, o_pixel_data_valid, o_busy, o_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {o_s_ready, o_pixel_data_valid, o_busy, o_done});
        end
        checks++;
        if (o_pixel_data !== 8'h00 || o_line_cnt !== 10'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h lines=%0d want 0/0", o_pixel_data, o_line_cnt);
        end
    endtask

    task automatic test_preload();
        clear_frame();
        i_s_valid = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (PRE * W + 8) step();
        checks++;
        if (outq.size() != PRE * W) begin
            errors++;
            $display("FAIL preload_count got %0d want %0d", outq.size(), PRE * W);
        end
        for (int k = 0; k < outq.size() && k < inq.size(); k++) begin
            checks++;
            if (outq[k] !== inq[k]) begin
                errors++;
                $display("FAIL preload_order idx %0d got %h want %h", k, outq[k], inq[k]);
            end
        end
        checks++;
        if (o_s_ready !== 1'b0 || o_line_cnt !== 10'(PRE) || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL preload_wait got rdy=%b lines=%0d busy=%b want 0/%0d/1", o_s_ready, o_line_cnt, o_busy, PRE);
        end
        // A start pulse during the frame must have no effect.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        checks++;
        if (o_line_cnt !== 10'(PRE) || o_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored got lines=%0d rdy=%b want %0d/0", o_line_cnt, o_s_ready, PRE);
        end
    endtask

    task automatic test_release();
        int base;
        base = outq.size();
        pulse_intr();
        repeat (W + 6) step();
        checks++;
        if (outq.size() - base != W) begin
            errors++;
            $display("FAIL release_count got %0d want %0d", outq.size() - base, W);
        end
        checks++;
        if (o_line_cnt !== 10'(PRE + 1) || o_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_wait got lines=%0d rdy=%b want %0d/0", o_line_cnt, o_s_ready, PRE + 1);
        end
    endtask

    task automatic test_simultaneous();
        int hi;
        pulse_intr();
        step();
        repeat (W - 1) step();
        // The intr arrives in the same cycle as the last pixel of line 5.
        i_intr = 1'b1;
        step();
        i_intr = 1'b0;
        checks++;
        if (o_s_ready !== 1'b1 || o_line_cnt !== 10'(PRE + 2)) begin
            errors++;
            $display("FAIL simul_no_drop got rdy=%b lines=%0d want 1/%0d", o_s_ready, o_line_cnt, PRE + 2);
        end
        hi = 0;
        for (int i = 0; i < W; i++) begin
            if (o_s_ready) hi++;
            step();
        end
        checks++;
        if (hi != W) begin
            errors++;
            $display("FAIL simul_line6 got %0d ready cycles want %0d", hi, W);
        end
        checks++;
        if (o_s_ready !== 1'b0 || o_line_cnt !== 10'(PRE + 3)) begin
            errors++;
            $display("FAIL simul_wait got rdy=%b lines=%0d want 0/%0d", o_s_ready, o_line_cnt, PRE + 3);
        end
    endtask

    task automatic test_bubbles();
        int base;
        base = outq.size();
        pulse_intr();
        for (int i = 0; i < 300 && o_line_cnt != 10'(H); i++) begin
            i_s_valid = 1'($urandom_range(0, 1));
            step();
        end
        i_s_valid = 1'b1;
        checks++;
        if (o_line_cnt !== 10'(H)) begin
            errors++;
            $display("FAIL bubbles_timeout got lines=%0d want %0d", o_line_cnt, H);
        end
        checks++;
        if (outq.size() - base != W) begin
            errors++;
            $display("FAIL bubbles_count got %0d want %0d", outq.size() - base, W);
        end
        checks++;
        if (inq.size() != W * H) begin
            errors++;
            $display("FAIL bubbles_accepted got %0d want %0d", inq.size(), W * H);
        end
        for (int k = 0; k < outq.size() && k < inq.size(); k++) begin
            checks++;
            if (outq[k] !== inq[k]) begin
                errors++;
                $display("FAIL image_order idx %0d got %h want %h", k, outq[k], inq[k]);
            end
        end
    endtask

    task automatic test_frame_end();
        int r0;
        r0 = rdy_cnt;
        pulse_intr();
        pulse_intr();
        repeat (PAD * W + 10) step();
        checks++;
        if (rdy_cnt != r0) begin
            errors++;
            $display("FAIL pad_ready got %0d ready cycles want 0", rdy_cnt - r0);
        end
        checks++;
        if (outq.size() != (H + PAD) * W) begin
            errors++;
            $display("FAIL frame_count got %0d want %0d", outq.size(), (H + PAD) * W);
        end
        for (int k = H * W; k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== 8'h00) begin
                errors++;
                $display("FAIL pad_zero idx %0d got %h want 00", k, outq[k]);
            end
        end
        checks++;
        if (o_line_cnt !== 10'(H + PAD) || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_end got lines=%0d busy=%b want %0d/0", o_line_cnt, o_busy, H + PAD);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_vld_cyc + 1) begin
            errors++;
            $display("FAIL done_pulse got cnt=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_vld_cyc + 1);
        end
    endtask

    task automatic test_restart();
        clear_frame();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (PRE * W + 8) step();
        checks++;
        if (outq.size() != PRE * W || o_line_cnt !== 10'(PRE) || o_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL restart got %0d px lines=%0d rdy=%b want %0d/%0d/0", outq.size(), o_line_cnt, o_s_ready, PRE * W, PRE);
        end
        checks++;
        if (outq.size() == 0 || inq.size() == 0 || outq[0] !== inq[0]) begin
            errors++;
            $display("FAIL restart_first got %0d outputs want first pixel match", outq.size());
        end
    endtask

    task automatic test_reset_midline();
        pulse_intr();
        step();
        repeat (10) step();
        i_s_valid = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        checks++;
        if ({o_s_ready, o_pixel_data_valid, o_busy, o_done} !== 4'b0000 ||
            o_pixel_data !== 8'h00 || o_line_cnt !== 10'd0) begin
            errors++;
            $display("FAIL midline_reset got rdy=%b vld=%b busy=%b done=%b data=%h lines=%0d want all 0",
                     o_s_ready, o_pixel_data_valid, o_busy, o_done, o_pixel_data, o_line_cnt);
        end
        clear_frame();
        i_s_valid = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (W) step();
        checks++;
        if (o_line_cnt !== 10'd1 || outq.size() != W) begin
            errors++;
            $display("FAIL midline_restart got lines=%0d px=%0d want 1/%0d", o_line_cnt, outq.size(), W);
        end
        for (int k = 0; k < outq.size() && k < inq.size(); k++) begin
            checks++;
            if (outq[k] !== inq[k]) begin
                errors++;
                $display("FAIL midline_order idx %0d got %h want %h", k, outq[k], inq[k]);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_s_valid = 1'b0;
        i_intr = 1'b0;
        i_s_data = pix(0);
        test_reset();
        test_preload();
        test_release();
        test_simultaneous();
        test_bubbles();
        test_frame_end();
        test_restart();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
